// File: rtl/duck_spawn_gen.sv
// duck_spawn_gen: draws a duck spawn point (x, y), a flight direction and a
// speed from a free-running 16-bit RNG word. Each coordinate is drawn by
// rejection sampling with a bounded number of tries and a fixed fallback
// value. The result is held under a valid/ack handshake until it is taken.
//
// Optional build macro: SPAWN_STATS_EN
//   defined   -> reject_count is an 8-bit saturating count of rejected
//                candidates (fallback cycles included), cleared only by reset.
//   undefined -> reject_count is tied to 0.
module duck_spawn_gen #(
    parameter int X_MAX     = 600,  // x range 0..X_MAX-1, X_MAX <= 1024
    parameter int Y_MIN     = 40,   // lowest legal row
    parameter int Y_MAX     = 360,  // highest legal row (inclusive)
    parameter int MAX_TRIES = 8     // candidates per coordinate, 1..255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] rnd,
    input  logic        req,
    input  logic        ack,
    output logic        busy,
    output logic        valid,
    output logic [9:0]  spawn_x,
    output logic [9:0]  spawn_y,
    output logic [1:0]  spawn_dir,
    output logic [2:0]  spawn_speed,
    output logic [7:0]  reject_count
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        GEN_X  = 3'd1,
        GEN_Y  = 3'd2,
        GEN_DS = 3'd3,
        HOLD   = 3'd4
    } state_t;

    // 11-bit limit so that X_MAX = 1024 accepts every 10-bit candidate.
    localparam logic [10:0] X_LIMIT    = 11'(X_MAX);
    localparam logic [9:0]  X_FALLBACK = 10'(X_MAX >> 1);
    localparam logic [8:0]  Y_SPAN     = 9'(Y_MAX - Y_MIN);
    localparam logic [9:0]  Y_BASE     = 10'(Y_MIN);
    localparam logic [7:0]  LAST_TRY   = 8'(MAX_TRIES - 1);

    state_t     state;
    state_t     state_next;
    logic [7:0] try_cnt;

    logic       x_ok;
    logic       y_ok;
    logic       last_try;
    logic [2:0] speed_raw;

    // Only rnd[9:0] is ever consumed; the upper bits are deliberately ignored.
    logic       unused_rnd;
    assign unused_rnd = ^rnd[15:10];

    assign x_ok      = {1'b0, rnd[9:0]} < X_LIMIT;
    assign y_ok      = rnd[8:0] <= Y_SPAN;
    assign last_try  = (try_cnt == LAST_TRY);
    assign speed_raw = rnd[4:2];

    // Status outputs decode the registered state only, so rnd never reaches
    // an output combinationally.
    assign busy  = (state != IDLE);
    assign valid = (state == HOLD);

    // State register.
    // NOTE: clocked state uses non-blocking (<=) so every register samples the
    // pre-edge values; blocking assignments here would create order-dependent
    // simulation races.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Next-state decode.
    // NOTE: state_next gets its default before the case so every path assigns
    // it; a missing assignment on any path would infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (req)             state_next = GEN_X;
            GEN_X:   if (x_ok || last_try) state_next = GEN_Y;
            GEN_Y:   if (y_ok || last_try) state_next = GEN_DS;
            GEN_DS:                        state_next = HOLD;
            HOLD:    if (ack)             state_next = IDLE;
            default:                       state_next = IDLE;
        endcase
    end

    // Try counter and result registers; results are only written while
    // drawing, so they stay frozen through HOLD and the following IDLE.
    always_ff @(posedge clk) begin
        if (reset) begin
            try_cnt     <= '0;
            spawn_x     <= '0;
            spawn_y     <= '0;
            spawn_dir   <= '0;
            spawn_speed <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req) try_cnt <= '0;
                end
                GEN_X: begin
                    if (x_ok) begin
                        spawn_x <= rnd[9:0];
                        try_cnt <= '0;
                    end else if (last_try) begin
                        spawn_x <= X_FALLBACK;
                        try_cnt <= '0;
                    end else begin
                        try_cnt <= try_cnt + 8'd1;
                    end
                end
                GEN_Y: begin
                    if (y_ok) begin
                        spawn_y <= {1'b0, rnd[8:0]} + Y_BASE;
                        try_cnt <= '0;
                    end else if (last_try) begin
                        spawn_y <= Y_BASE;
                        try_cnt <= '0;
                    end else begin
                        try_cnt <= try_cnt + 8'd1;
                    end
                end
                GEN_DS: begin
                    spawn_dir   <= rnd[1:0];
                    spawn_speed <= (speed_raw == 3'd0) ? 3'd1 : speed_raw;
                end
                default: ;
            endcase
        end
    end

`ifdef SPAWN_STATS_EN
    logic reject;
    assign reject = ((state == GEN_X) && !x_ok) || ((state == GEN_Y) && !y_ok);

    // Saturating rejection counter; survives ack, cleared only by reset.
    always_ff @(posedge clk) begin
        if (reset)                               reject_count <= '0;
        else if (reject && reject_count != 8'hFF) reject_count <= reject_count + 8'd1;
    end
`else
    assign reject_count = '0;
`endif

endmodule
